// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush control for the in-order MIPS pipeline.
// A shift-register scoreboard of in-flight writers drives load-use stall, flush and EX forward selects.
module pipe_hazard_ctrl #(
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int CNT_W      = 16,
   localparam int FSW       = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_wr_reg,
   input  logic              id_is_load,
   input  logic              branch_taken,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              flush_ifid,
   output logic              stall,
   output logic [FSW-1:0]    fwd_sel_rs,
   output logic [FSW-1:0]    fwd_sel_rt,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   typedef struct packed {
      logic              vld;
      logic              wr;
      logic [REG_AW-1:0] rd;
      logic              ld;
   } sb_entry_t;

   // The final stage writes a write-first register file and is never a
   // forwarding source, so only stages 0..DEPTH-2 need storage.
   sb_entry_t [DEPTH-2:0] sb;

   logic [1:0][REG_AW-1:0] src;
   logic [1:0]             used;
   logic [1:0][FSW-1:0]    sel_nxt;
   logic [1:0]             lu;
   logic                   issue;

   assign src  = {id_rt, id_rs};
   assign used = {id_rt_used, id_rs_used};

   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      sel_nxt = '0;
      lu      = '0;
      for (int s = 0; s < 2; s++) begin
         for (int k = DEPTH-2; k >= 0; k--) begin
            if (sb[k].vld && sb[k].wr && sb[k].rd == src[s] &&
                src[s] != '0 && used[s]) begin
               sel_nxt[s] = FSW'(k+1);
               lu[s]      = sb[k].ld && ((k+1) < LOAD_STAGE);
            end
         end
      end
   end

   assign stall      = id_valid & ~branch_taken & (|lu);
   assign issue      = id_valid & ~stall & ~branch_taken;
   assign pc_write   = ~stall;
   assign ifid_write = ~stall;
   assign flush_ifid = branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb          <= '0;
         fwd_sel_rs  <= '0;
         fwd_sel_rt  <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         for (int i = DEPTH-2; i > 0; i--) sb[i] <= sb[i-1];
         sb[0]      <= issue ? sb_entry_t'{1'b1, id_wr_en, id_wr_reg, id_is_load} : '0;
         fwd_sel_rs <= issue ? sel_nxt[0] : '0;
         fwd_sel_rt <= issue ? sel_nxt[1] : '0;
         if (stall && !(&stall_count))        stall_count <= stall_count + 1'b1;
         if (branch_taken && !(&flush_count)) flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle vector table with a select scoreboard,
// a narrow-counter instance for saturation, and a hand-written async reset sequence.
module tb_pipe_hazard_ctrl;

   typedef struct {
      logic       vld;
      logic [4:0] rs, rt;
      logic       rsu, rtu, wr;
      logic [4:0] wd;
      logic       ld, bt;
      logic       e_stall;
      logic [1:0] e_rs, e_rt;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
   logic        id_wr_en = 1'b0, id_is_load = 1'b0, branch_taken = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_wr_reg = '0;
   logic        pc_write, ifid_write, flush_ifid, stall;
   logic [1:0]  fwd_sel_rs, fwd_sel_rt;
   logic [15:0] stall_count, flush_count;
   logic        s_pc, s_ifid, s_flush, s_stall;
   logic [1:0]  s_rs, s_rt;
   logic [2:0]  sat_sc, sat_fc;

   pipe_hazard_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
      .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .branch_taken(branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .flush_ifid(flush_ifid), .stall(stall),
      .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt),
      .stall_count(stall_count), .flush_count(flush_count));

   pipe_hazard_ctrl #(.CNT_W(3)) u_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
      .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .branch_taken(branch_taken),
      .pc_write(s_pc), .ifid_write(s_ifid), .flush_ifid(s_flush), .stall(s_stall),
      .fwd_sel_rs(s_rs), .fwd_sel_rt(s_rt),
      .stall_count(sat_sc), .flush_count(sat_fc));

   always #5 clk = ~clk;

   int         nvec = 0, nerr = 0;
   int         exp_sc = 0, exp_fc = 0;
   vec_t       tbl[$];
   logic [3:0] sel_q[$];

   function automatic vec_t mk(logic vld, logic [4:0] rs, logic [4:0] rt, logic rsu, logic rtu,
                               logic wr, logic [4:0] wd, logic ld, logic bt,
                               logic es, logic [1:0] ers, logic [1:0] ert);
      vec_t v;
      v.vld = vld; v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu; v.wr = wr;
      v.wd = wd; v.ld = ld; v.bt = bt; v.e_stall = es; v.e_rs = ers; v.e_rt = ert;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_rs_used = v.rsu; id_rt_used = v.rtu;
      id_wr_en = v.wr; id_wr_reg = v.wd; id_is_load = v.ld; branch_taken = v.bt;
   endtask

   // Called 1ns after a rising edge; consumes exactly one clock.
   task automatic apply(input vec_t v, input int idx);
      logic [3:0] e;
      drive(v);
      #1;
      chk($sformatf("stall[%0d]", idx), stall, v.e_stall);
      chk($sformatf("pc_write[%0d]", idx), pc_write, !v.e_stall);
      chk($sformatf("ifid_write[%0d]", idx), ifid_write, !v.e_stall);
      chk($sformatf("flush_ifid[%0d]", idx), flush_ifid, v.bt);
      sel_q.push_back({v.e_rs, v.e_rt});
      exp_sc += int'(v.e_stall);
      exp_fc += int'(v.bt);
      @(posedge clk); #1;
      if (sel_q.size() == 0) begin
         chk($sformatf("sel_q_empty[%0d]", idx), 1, 0);
      end else begin
         e = sel_q.pop_front();
         chk($sformatf("fwd_sel_rs[%0d]", idx), fwd_sel_rs, e[3:2]);
         chk($sformatf("fwd_sel_rt[%0d]", idx), fwd_sel_rt, e[1:0]);
      end
      chk($sformatf("stall_count[%0d]", idx), stall_count, exp_sc);
      chk($sformatf("flush_count[%0d]", idx), flush_count, exp_fc);
      chk($sformatf("sat_stall[%0d]", idx), sat_sc, (exp_sc > 7) ? 7 : exp_sc);
      chk($sformatf("sat_flush[%0d]", idx), sat_fc, (exp_fc > 7) ? 7 : exp_fc);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      vec_t nop;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // dependent add pair
      tbl.push_back(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 3, 5, 1, 1, 1, 4, 0, 0, 0, 1, 0));
      repeat (3) tbl.push_back(nop);
      // distance 2 forwards from stage 2; distance 3 reads the register file
      tbl.push_back(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 10, 11, 1, 1, 1, 12, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 6, 3, 1, 1, 1, 13, 0, 0, 0, 0, 2));
      repeat (3) tbl.push_back(nop);
      tbl.push_back(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 10, 11, 1, 1, 1, 12, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 10, 11, 1, 1, 1, 14, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 6, 3, 1, 1, 1, 13, 0, 0, 0, 0, 0));
      repeat (3) tbl.push_back(nop);
      // lw $8 then add $9,$8,$8: one stall, then forward from stage 2
      tbl.push_back(mk(1, 1, 0, 1, 0, 1, 8, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8, 8, 1, 1, 1, 9, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 2, 2));
      repeat (3) tbl.push_back(nop);
      // $0 producers and unused sources never match; youngest $7 wins
      tbl.push_back(mk(1, 1, 2, 1, 1, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 5, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2, 1, 1, 1, 6, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 6, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2, 1, 1, 1, 7, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2, 1, 1, 1, 7, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 7, 7, 1, 1, 1, 9, 0, 0, 0, 1, 1));
      repeat (3) tbl.push_back(nop);
      // repeated stall + flush rounds drive the 3-bit counters into saturation
      for (int i = 0; i < 8; i++) begin
         tbl.push_back(mk(1, 20, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0));
         tbl.push_back(mk(1, 8, 8, 1, 1, 1, 9, 0, 0, 1, 0, 0));
         tbl.push_back(mk(1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 2, 2));
         tbl.push_back(mk(1, 9, 9, 1, 1, 1, 10, 0, 1, 0, 0, 0));
         tbl.push_back(nop);
      end
      // load-use coinciding with a taken branch: flush wins, no stall
      tbl.push_back(mk(1, 20, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8, 8, 1, 1, 1, 9, 0, 1, 0, 0, 0));
      repeat (3) tbl.push_back(nop);

      // reset state, with branch_taken high to observe the combinational path
      branch_taken = 1'b1;
      #7;
      chk("rst_stall", stall, 0);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_ifid_write", ifid_write, 1);
      chk("rst_flush", flush_ifid, 1);
      chk("rst_sel_rs", fwd_sel_rs, 0);
      chk("rst_sel_rt", fwd_sel_rt, 0);
      chk("rst_stall_count", stall_count, 0);
      chk("rst_flush_count", flush_count, 0);
      branch_taken = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // asynchronous reset in the middle of a load-use stall
      apply(mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0), 1000);
      apply(mk(1, 1, 0, 1, 0, 1, 8, 1, 0, 0, 1, 0), 1001);
      drive(mk(1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 0, 0));
      #1;
      chk("pre_rst_stall", stall, 1);
      chk("pre_rst_sel_rs", fwd_sel_rs, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_pc_write", pc_write, 1);
      chk("mid_rst_sel_rs", fwd_sel_rs, 0);
      chk("mid_rst_sel_rt", fwd_sel_rt, 0);
      chk("mid_rst_stall_count", stall_count, 0);
      chk("mid_rst_flush_count", flush_count, 0);
      chk("mid_rst_sat_stall", sat_sc, 0);
      chk("mid_rst_sat_flush", sat_fc, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      exp_sc = 0;
      exp_fc = 0;
      sel_q.delete();
      apply(mk(1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 0, 0), 2000);
      apply(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0), 2001);
      apply(mk(1, 3, 5, 1, 1, 1, 4, 0, 0, 0, 1, 0), 2002);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the in-order pipelined MIPS core.
- Sits between the ID stage and the downstream pipeline registers.
- Keeps its own DEPTH-entry scoreboard of in-flight destination registers.
- From the scoreboard it generates the load-use stall, the branch flush, and registered forwarding selects aligned with the EX stage; it also keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width (2**REG_AW architectural registers; register 0 hardwired zero).
- DEPTH, 3, tracked stages after ID (index 0=EX, 1=MEM, 2=WB); minimum 2.
- LOAD_STAGE, 2, lowest forwarding source index at which load data is available (2 = MEM/WB output).
- CNT_W, 16, performance counter width.
- FSW, $clog2(DEPTH+1), forwarding select width (derived; not overridable).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_AW  source register 1 of the ID instruction
- id_rt  in  REG_AW  source register 2 of the ID instruction
- id_rs_used  in  1  ID instruction reads rs
- id_rt_used  in  1  ID instruction reads rt
- id_wr_en  in  1  ID instruction writes a register
- id_wr_reg  in  REG_AW  destination register of the ID instruction
- id_is_load  in  1  ID instruction is a load
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register update enable
- flush_ifid  out  1  clear IF/ID to a bubble
- stall  out  1  load-use stall active
- fwd_sel_rs  out  FSW  EX operand-1 source (0 = register file, k = output of stage k)
- fwd_sel_rt  out  FSW  EX operand-2 source, same encoding
- stall_count  out  CNT_W  cycles stalled, saturating
- flush_count  out  CNT_W  flushes issued, saturating

Behaviour:
- Scoreboard entry[i], i = 0..DEPTH-1, holds {valid, wr_en, wr_reg, is_load}.
- On every clock edge the scoreboard shifts: entry[i] <= entry[i-1] for i >= 1. The last entry retires.
- entry[0] loads the ID fields only when id_valid=1, stall=0 and branch_taken=0. Otherwise entry[0] loads a bubble (valid=0).
- Match rule: stage k matches source s when entry[k].valid, entry[k].wr_en and entry[k].wr_reg == s all hold, s != 0, and the source's used bit is set.
- Only k = 0..DEPTH-2 are considered. A producer in stage DEPTH-1 writes the register file this cycle, and the register file is write-first.
- Forwarding: for each source take the smallest matching k (the youngest producer wins). Next-cycle select = k+1; select = 0 if no match.
- fwd_sel_rs and fwd_sel_rt are registered at the same edge entry[0] loads. They are forced to 0 when entry[0] loads a bubble.
- Load-use: stall is combinational and equals 1 when id_valid=1, branch_taken=0, and either source's youngest match k has is_load=1 with k+1 < LOAD_STAGE.
- Stall outputs: pc_write = ifid_write = ~stall. A bubble is inserted into EX.
- Flush: flush_ifid = branch_taken (combinational). The ID instruction is squashed by the bubble into entry[0]. Flush has priority: with branch_taken=1, stall=0.
- Counters:
  - stall_count += 1 in each cycle with stall=1.
  - flush_count += 1 in each cycle with branch_taken=1.
  - Both hold at all-ones (saturate).
- Reset: asynchronous while rst_n=0. All entries invalid; fwd_sel_rs = fwd_sel_rt = 0; both counters = 0.
  - Combinational outputs then evaluate to stall=0, pc_write=1, ifid_write=1, flush_ifid = branch_taken.
  - Reset mid-stall discards all in-flight state; no stall persists after release.
- Stall length: a stall lasts exactly until the load reaches a stage with k+1 >= LOAD_STAGE. With defaults this is 1 cycle.

Test Plan:
- Reset, then add $3,$1,$2 followed by add $4,$3,$5 → stall=0. When the second add is in EX, fwd_sel_rs=1 and fwd_sel_rt=0.
- Producer of $3, one unrelated instruction, then consumer of $3 in rt → fwd_sel_rt=2. With a distance of 3 → fwd_sel_rt=0.
- lw $8,0($1) followed by add $9,$8,$8:
  - One cycle with stall=1, pc_write=0, ifid_write=0, and a bubble in EX.
  - The add then enters EX with fwd_sel_rs=fwd_sel_rt=2.
  - stall_count=1.
- Producers to $0, and id_rs_used=0 with id_rs matching a producer → no stall and selects 0. Two in-flight producers of $7 → the younger one wins (sel=1).
- Load-use condition with branch_taken=1 in the same cycle:
  - stall=0, flush_ifid=1, and a bubble into EX.
  - flush_count increments, stall_count unchanged.
  - Preload both counters near all-ones and confirm they saturate.
- Assert rst_n=0 asynchronously mid-stall → stall and selects drop without a clock edge, and counters read 0. On release, normal issue resumes.
